// File: rtl/riscv_core_redirect_controller.sv
// Purpose: turns a resolved EX control-flow event into a flush/redirect sequence and a BTB training update.
// Latency: flush for FLUSH_CYCLES cycles after acceptance, redirect in the next cycle; BTB update visible the cycle after acceptance.
// Backpressure: redirect is held until i_fetch_ready; BTB buffer is held until i_btb_ready; EX is stalled meanwhile.
module riscv_core_redirect_controller #(
   parameter int ALEN         = 64,
   parameter int FLUSH_CYCLES = 2,
   // Width of the internal misprediction counter; the output is zero-extended to 32 bits.
   parameter int CNT_W        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ex_valid,
   input  logic            i_is_branch,
   input  logic            i_is_jump,
   input  logic            i_is_taken,
   input  logic            i_mis_prediction,
   input  logic [ALEN-1:0] i_recovery_address,
   input  logic [ALEN-1:0] i_ex_pc,
   input  logic [ALEN-1:0] i_ex_target,
   input  logic            i_fetch_ready,
   input  logic            i_btb_ready,
   output logic            o_stall_ex,
   output logic            o_flush,
   output logic            o_redirect_valid,
   output logic [ALEN-1:0] o_redirect_address,
   output logic            o_btb_upd_valid,
   output logic [ALEN-1:0] o_btb_upd_pc,
   output logic [ALEN-1:0] o_btb_upd_target,
   output logic            o_btb_upd_taken,
   output logic [31:0]     o_mispredict_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state_q, state_d;
   logic [3:0]       flush_cnt_q, flush_cnt_d;
   logic [ALEN-1:0]  redir_addr_q, redir_addr_d;
   logic             upd_full_q, upd_full_d;
   logic [ALEN-1:0]  upd_pc_q, upd_pc_d;
   logic [ALEN-1:0]  upd_tgt_q, upd_tgt_d;
   logic             upd_taken_q, upd_taken_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic accept;

   // EX is held while a sequence is in flight or the BTB buffer cannot drain this cycle.
   assign o_stall_ex = (state_q != ST_IDLE) | (upd_full_q & ~i_btb_ready);
   assign accept     = i_ex_valid & (i_is_branch | i_is_jump) & ~o_stall_ex;

   assign o_flush            = (state_q == ST_FLUSH);
   assign o_redirect_valid   = (state_q == ST_REDIRECT);
   assign o_redirect_address = redir_addr_q;
   assign o_btb_upd_valid    = upd_full_q;
   assign o_btb_upd_pc       = upd_pc_q;
   assign o_btb_upd_target   = upd_tgt_q;
   assign o_btb_upd_taken    = upd_taken_q;
   assign o_mispredict_count = 32'(miss_cnt_q);

   // Next-state logic: FSM sequencing, BTB buffer write/drain and saturating miss counter.
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      redir_addr_d = redir_addr_q;
      upd_full_d   = upd_full_q;
      upd_pc_d     = upd_pc_q;
      upd_tgt_d    = upd_tgt_q;
      upd_taken_d  = upd_taken_q;
      miss_cnt_d   = miss_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && i_mis_prediction) begin
               redir_addr_d = i_recovery_address;
               flush_cnt_d  = FLUSH_INIT;
               state_d      = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Leaving at a count of 1 gives exactly FLUSH_CYCLES flush cycles.
            if (flush_cnt_q <= 4'd1) begin
               flush_cnt_d = 4'd0;
               state_d     = ST_REDIRECT;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         ST_REDIRECT: begin
            if (i_fetch_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Drain first so that a same-edge write overrides it.
      if (upd_full_q && i_btb_ready) begin
         upd_full_d = 1'b0;
      end
      if (accept) begin
         upd_full_d  = 1'b1;
         upd_pc_d    = i_ex_pc;
         upd_tgt_d   = i_ex_target;
         upd_taken_d = i_is_taken | i_is_jump;
      end

      if (accept && i_mis_prediction && (miss_cnt_q != CNT_MAX)) begin
         miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         flush_cnt_q  <= 4'd0;
         redir_addr_q <= '0;
         upd_full_q   <= 1'b0;
         upd_pc_q     <= '0;
         upd_tgt_q    <= '0;
         upd_taken_q  <= 1'b0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         redir_addr_q <= redir_addr_d;
         upd_full_q   <= upd_full_d;
         upd_pc_q     <= upd_pc_d;
         upd_tgt_q    <= upd_tgt_d;
         upd_taken_q  <= upd_taken_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_riscv_core_redirect_controller.sv
// Directed bench for the redirect controller: flush/redirect timing, BTB buffer handshake, reset abort, counter saturation.
// Built with FLUSH_CYCLES=2 and a 3-bit miss counter so saturation (at 7) is reachable quickly.
// Inputs are driven 1 time unit after the rising edge and outputs are checked at that same point.
module tb_riscv_core_redirect_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_ex_valid, i_is_branch, i_is_jump, i_is_taken, i_mis_prediction;
   logic [63:0] i_recovery_address, i_ex_pc, i_ex_target;
   logic        i_fetch_ready, i_btb_ready;
   logic        o_stall_ex, o_flush, o_redirect_valid;
   logic [63:0] o_redirect_address;
   logic        o_btb_upd_valid;
   logic [63:0] o_btb_upd_pc, o_btb_upd_target;
   logic        o_btb_upd_taken;
   logic [31:0] o_mispredict_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   riscv_core_redirect_controller #(
      .ALEN(64),
      .FLUSH_CYCLES(2),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_ex_valid(i_ex_valid),
      .i_is_branch(i_is_branch),
      .i_is_jump(i_is_jump),
      .i_is_taken(i_is_taken),
      .i_mis_prediction(i_mis_prediction),
      .i_recovery_address(i_recovery_address),
      .i_ex_pc(i_ex_pc),
      .i_ex_target(i_ex_target),
      .i_fetch_ready(i_fetch_ready),
      .i_btb_ready(i_btb_ready),
      .o_stall_ex(o_stall_ex),
      .o_flush(o_flush),
      .o_redirect_valid(o_redirect_valid),
      .o_redirect_address(o_redirect_address),
      .o_btb_upd_valid(o_btb_upd_valid),
      .o_btb_upd_pc(o_btb_upd_pc),
      .o_btb_upd_target(o_btb_upd_target),
      .o_btb_upd_taken(o_btb_upd_taken),
      .o_mispredict_count(o_mispredict_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      i_ex_valid       = 1'b0;
      i_is_branch      = 1'b0;
      i_is_jump        = 1'b0;
      i_is_taken       = 1'b0;
      i_mis_prediction = 1'b0;
   endtask

   task automatic drive_ex(input logic br, input logic jmp, input logic tkn, input logic mis,
                           input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] rec);
      i_ex_valid         = 1'b1;
      i_is_branch        = br;
      i_is_jump          = jmp;
      i_is_taken         = tkn;
      i_mis_prediction   = mis;
      i_ex_pc            = pc;
      i_ex_target        = tgt;
      i_recovery_address = rec;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (o_stall_ex !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0h want 0", o_stall_ex); end
      total++; if (o_flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %0h want 0", o_flush); end
      total++; if (o_redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_rv: got %0h want 0", o_redirect_valid); end
      total++; if (o_redirect_address !== 64'h0) begin bad++; $display("FAIL rst_raddr: got %0h want 0", o_redirect_address); end
      total++; if (o_btb_upd_valid !== 1'b0) begin bad++; $display("FAIL rst_upd_valid: got %0h want 0", o_btb_upd_valid); end
      total++; if (o_btb_upd_pc !== 64'h0) begin bad++; $display("FAIL rst_upd_pc: got %0h want 0", o_btb_upd_pc); end
      total++; if (o_mispredict_count !== 32'h0) begin bad++; $display("FAIL rst_count: got %0h want 0", o_mispredict_count); end
      rst = 1'b0;
   endtask

   // Correctly predicted taken branch trains the BTB without flush or redirect.
   task automatic test_predicted_taken();
      i_btb_ready = 1'b0;
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 64'h200, 64'h0);
      step();
      clear_ex();
      total++; if (o_btb_upd_valid !== 1'b1) begin bad++; $display("FAIL pred_upd_valid: got %0h want 1", o_btb_upd_valid); end
      total++; if (o_btb_upd_pc !== 64'h100) begin bad++; $display("FAIL pred_upd_pc: got %0h want 100", o_btb_upd_pc); end
      total++; if (o_btb_upd_target !== 64'h200) begin bad++; $display("FAIL pred_upd_tgt: got %0h want 200", o_btb_upd_target); end
      total++; if (o_btb_upd_taken !== 1'b1) begin bad++; $display("FAIL pred_upd_taken: got %0h want 1", o_btb_upd_taken); end
      total++; if (o_flush !== 1'b0 || o_redirect_valid !== 1'b0) begin bad++; $display("FAIL pred_no_flush: got flush=%0h rv=%0h want 0/0", o_flush, o_redirect_valid); end
      total++; if (o_stall_ex !== 1'b1) begin bad++; $display("FAIL pred_stall_full: got %0h want 1", o_stall_ex); end
      i_btb_ready = 1'b1;
      #1;
      total++; if (o_stall_ex !== 1'b0) begin bad++; $display("FAIL pred_stall_ready: got %0h want 0", o_stall_ex); end
      step();
      total++; if (o_btb_upd_valid !== 1'b0) begin bad++; $display("FAIL pred_drain: got %0h want 0", o_btb_upd_valid); end
      total++; if (o_mispredict_count !== 32'h0) begin bad++; $display("FAIL pred_count: got %0h want 0", o_mispredict_count); end
   endtask

   // Events without i_ex_valid, or without branch/jump, must not be accepted.
   task automatic test_ignored();
      drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 64'h900, 64'h940, 64'h980);
      i_ex_valid = 1'b0;
      step();
      total++; if (o_flush !== 1'b0 || o_btb_upd_valid !== 1'b0) begin bad++; $display("FAIL ign_novalid: got flush=%0h upd=%0h want 0/0", o_flush, o_btb_upd_valid); end
      drive_ex(1'b0, 1'b0, 1'b1, 1'b1, 64'h900, 64'h940, 64'h980);
      step();
      clear_ex();
      total++; if (o_flush !== 1'b0 || o_btb_upd_valid !== 1'b0) begin bad++; $display("FAIL ign_nobr: got flush=%0h upd=%0h want 0/0", o_flush, o_btb_upd_valid); end
      total++; if (o_mispredict_count !== 32'h0) begin bad++; $display("FAIL ign_count: got %0h want 0", o_mispredict_count); end
   endtask

   // Mispredicted branch: flush N+1..N+2, redirect N+3, next event at N+4.
   task automatic test_mispredict();
      i_fetch_ready = 1'b1;
      i_btb_ready   = 1'b1;
      drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 64'h300, 64'h340, 64'h400);
      step();
      clear_ex();
      // cycle N+1
      total++; if (o_flush !== 1'b1 || o_redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_n1: got flush=%0h rv=%0h want 1/0", o_flush, o_redirect_valid); end
      total++; if (o_stall_ex !== 1'b1) begin bad++; $display("FAIL mis_n1_stall: got %0h want 1", o_stall_ex); end
      total++; if (o_mispredict_count !== 32'h1) begin bad++; $display("FAIL mis_count: got %0h want 1", o_mispredict_count); end
      total++; if (o_btb_upd_valid !== 1'b1 || o_btb_upd_pc !== 64'h300 || o_btb_upd_taken !== 1'b0) begin bad++; $display("FAIL mis_upd: got v=%0h pc=%0h tk=%0h want 1/300/0", o_btb_upd_valid, o_btb_upd_pc, o_btb_upd_taken); end
      step();
      // cycle N+2
      total++; if (o_flush !== 1'b1 || o_redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_n2: got flush=%0h rv=%0h want 1/0", o_flush, o_redirect_valid); end
      total++; if (o_stall_ex !== 1'b1) begin bad++; $display("FAIL mis_n2_stall: got %0h want 1", o_stall_ex); end
      step();
      // cycle N+3
      total++; if (o_flush !== 1'b0 || o_redirect_valid !== 1'b1) begin bad++; $display("FAIL mis_n3: got flush=%0h rv=%0h want 0/1", o_flush, o_redirect_valid); end
      total++; if (o_redirect_address !== 64'h400) begin bad++; $display("FAIL mis_raddr: got %0h want 400", o_redirect_address); end
      total++; if (o_stall_ex !== 1'b1) begin bad++; $display("FAIL mis_n3_stall: got %0h want 1", o_stall_ex); end
      step();
      // cycle N+4: idle, a jump (not taken flag) must be accepted here
      total++; if (o_redirect_valid !== 1'b0 || o_flush !== 1'b0 || o_stall_ex !== 1'b0) begin bad++; $display("FAIL mis_n4: got rv=%0h flush=%0h stall=%0h want 0/0/0", o_redirect_valid, o_flush, o_stall_ex); end
      drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 64'h800, 64'h880, 64'h0);
      step();
      clear_ex();
      total++; if (o_btb_upd_pc !== 64'h800 || o_btb_upd_taken !== 1'b1) begin bad++; $display("FAIL jump_upd: got pc=%0h tk=%0h want 800/1", o_btb_upd_pc, o_btb_upd_taken); end
      step();
   endtask

   // Redirect held by fetch backpressure; EX events meanwhile are ignored.
   task automatic test_fetch_stall();
      i_fetch_ready = 1'b0;
      i_btb_ready   = 1'b0;
      drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 64'h500, 64'h540, 64'h400);
      step();
      clear_ex();
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 64'hBAD0 + 64'(i), 64'hDEAD, 64'hBEEF);
         total++; if (o_redirect_valid !== 1'b1 || o_redirect_address !== 64'h400) begin bad++; $display("FAIL hold_rv_%0d: got rv=%0h addr=%0h want 1/400", i, o_redirect_valid, o_redirect_address); end
         step();
         total++; if (o_btb_upd_pc !== 64'h500 || o_btb_upd_valid !== 1'b1) begin bad++; $display("FAIL hold_btb_%0d: got v=%0h pc=%0h want 1/500", i, o_btb_upd_valid, o_btb_upd_pc); end
      end
      clear_ex();
      total++; if (o_redirect_valid !== 1'b1 || o_redirect_address !== 64'h400) begin bad++; $display("FAIL hold_rv_end: got rv=%0h addr=%0h want 1/400", o_redirect_valid, o_redirect_address); end
      i_fetch_ready = 1'b1;
      step();
      total++; if (o_redirect_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got %0h want 0", o_redirect_valid); end
      total++; if (o_mispredict_count !== 32'h2) begin bad++; $display("FAIL hold_count: got %0h want 2", o_mispredict_count); end
   endtask

   // Full BTB buffer stalls EX; ready plus a new event replaces the entry.
   task automatic test_btb_backpressure();
      total++; if (o_stall_ex !== 1'b1) begin bad++; $display("FAIL bp_stall: got %0h want 1", o_stall_ex); end
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h600, 64'h680, 64'h0);
      step();
      total++; if (o_btb_upd_pc !== 64'h500) begin bad++; $display("FAIL bp_blocked: got %0h want 500", o_btb_upd_pc); end
      i_btb_ready = 1'b1;
      #1;
      total++; if (o_stall_ex !== 1'b0) begin bad++; $display("FAIL bp_unstall: got %0h want 0", o_stall_ex); end
      step();
      clear_ex();
      total++; if (o_btb_upd_valid !== 1'b1 || o_btb_upd_pc !== 64'h600 || o_btb_upd_target !== 64'h680) begin bad++; $display("FAIL bp_write_wins: got v=%0h pc=%0h tgt=%0h want 1/600/680", o_btb_upd_valid, o_btb_upd_pc, o_btb_upd_target); end
      step();
      total++; if (o_btb_upd_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0h want 0", o_btb_upd_valid); end
   endtask

   // Reset in the first flush cycle aborts the sequence.
   task automatic test_reset_mid_flush();
      int rv_seen;
      rv_seen = 0;
      i_fetch_ready = 1'b1;
      i_btb_ready   = 1'b0;
      drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 64'hA00, 64'hA40, 64'h700);
      step();
      clear_ex();
      total++; if (o_flush !== 1'b1) begin bad++; $display("FAIL rmf_flush: got %0h want 1", o_flush); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if ({o_stall_ex, o_flush, o_redirect_valid, o_btb_upd_valid, o_btb_upd_taken} !== 5'b0) begin bad++; $display("FAIL rmf_bits: got %0b want 0", {o_stall_ex, o_flush, o_redirect_valid, o_btb_upd_valid, o_btb_upd_taken}); end
      total++; if (o_redirect_address !== 64'h0 || o_btb_upd_pc !== 64'h0 || o_btb_upd_target !== 64'h0) begin bad++; $display("FAIL rmf_addr: got %0h/%0h/%0h want 0", o_redirect_address, o_btb_upd_pc, o_btb_upd_target); end
      total++; if (o_mispredict_count !== 32'h0) begin bad++; $display("FAIL rmf_count: got %0h want 0", o_mispredict_count); end
      for (int i = 0; i < 6; i++) begin
         if (o_redirect_valid === 1'b1 || o_flush === 1'b1) rv_seen++;
         step();
      end
      total++; if (rv_seen !== 0) begin bad++; $display("FAIL rmf_no_redirect: got %0d active cycles want 0", rv_seen); end
      i_btb_ready = 1'b1;
   endtask

   // Reduced-width counter saturates at 7.
   task automatic test_saturation();
      int exp_cnt;
      i_fetch_ready = 1'b1;
      i_btb_ready   = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 64'hC00, 64'hC40, 64'hD00);
         step();
         clear_ex();
         exp_cnt = (k > 7) ? 7 : k;
         total++; if (o_mispredict_count !== 32'(exp_cnt)) begin bad++; $display("FAIL sat_%0d: got %0d want %0d", k, o_mispredict_count, exp_cnt); end
         step();
         step();
         step();
      end
   endtask

   initial begin
      rst                = 1'b1;
      i_fetch_ready      = 1'b1;
      i_btb_ready        = 1'b1;
      i_recovery_address = 64'h0;
      i_ex_pc            = 64'h0;
      i_ex_target        = 64'h0;
      clear_ex();
      test_reset();
      test_predicted_taken();
      test_ignored();
      test_mispredict();
      test_fetch_stall();
      test_btb_backpressure();
      test_reset_mid_flush();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
